oe_contention_mon: RTL and testbench

- Clocked, parametrised contention monitor for the virtual-tester bus interface.
- Watches NUM_CH bidirectional pins where tester drivers and DUT output enables can collide.
- Per pin: detects contention in either of two modes, debounces it, and raises one event per contention episode.
- Keeps sticky status, saturating per-channel event counts and first-offender capture, with a masked clear handshake.
- Sits beside the tester pin model; its event outputs feed the logging block.

---
 rtl/oe_contention_mon.sv | 150 +++++++++++++++
 tb/tb_oe_contention_mon.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oe_contention_mon.sv
// Contention monitor for the virtual-tester bus interface.
// Each pin is checked for a tester-driver versus DUT-driver collision, either
// through the DUT output enable or through an X on the resolved pin value.
// A qualifying condition must persist for FILT_CYCLES consecutive cycles before
// it is declared, and each unbroken episode raises exactly one event. Sticky
// status, saturating event counters and the first offender are kept until
// cleared through the clr_req/clr_mask handshake.
module oe_contention_mon #(
    parameter int NUM_CH      = 2,
    parameter int FILT_CYCLES = 2,
    parameter int CNT_W       = 8,
    parameter int CH_W        = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      mode,
    input  logic [NUM_CH-1:0]         tst_drive,
    input  logic [NUM_CH-1:0]         tst_known,
    input  logic [NUM_CH-1:0]         dut_oe,
    input  logic [NUM_CH-1:0]         bus_x,
    input  logic                      clr_req,
    input  logic [NUM_CH-1:0]         clr_mask,
    output logic                      clr_ack,
    output logic                      evt_vld,
    output logic [NUM_CH-1:0]         evt_mask,
    output logic [CH_W-1:0]           evt_ch,
    output logic [NUM_CH-1:0]         sticky,
    output logic                      first_vld,
    output logic [CH_W-1:0]           first_ch,
    output logic [NUM_CH*CNT_W-1:0]   evt_cnt,
    output logic                      irq
);

    localparam logic [3:0] FILT = 4'(FILT_CYCLES);

    // Lowest set bit of a channel vector, 0 when the vector is empty.
    function automatic logic [CH_W-1:0] lowest(input logic [NUM_CH-1:0] v);
        lowest = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (v[i]) lowest = CH_W'(i);
        end
    endfunction

    logic [NUM_CH-1:0] q;
    logic [3:0]        fc_q [NUM_CH];
    logic [3:0]        fc_d [NUM_CH];
    logic [NUM_CH-1:0] ep_q;
    logic [NUM_CH-1:0] ep_d;
    logic [NUM_CH-1:0] decl;

    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] clr_vec;
    logic [NUM_CH-1:0] sticky_d;
    logic              first_hit;
    logic              first_vld_d;
    logic [CH_W-1:0]   first_ch_d;

    // Raw qualifier, consecutive-cycle filter and one-shot-per-episode declaration.
    always_comb begin
        q = {NUM_CH{enable}} & tst_drive & tst_known & (mode ? bus_x : dut_oe);
        for (int i = 0; i < NUM_CH; i++) begin
            // NOTE: every combinational output gets a default before any branch, otherwise a
            // path that skips the assignment would infer a latch.
            fc_d[i] = 4'd0;
            ep_d[i] = 1'b0;
            decl[i] = 1'b0;
            if (q[i]) begin
                fc_d[i] = (fc_q[i] >= FILT) ? FILT : fc_q[i] + 4'd1;
                decl[i] = (fc_d[i] == FILT) && !ep_q[i];
                ep_d[i] = ep_q[i] | decl[i];
            end
        end
    end

    // Filter counters and episode flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) fc_q[i] <= 4'd0;
            ep_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every register samples
            // the pre-edge values, independent of statement order.
            for (int i = 0; i < NUM_CH; i++) fc_q[i] <= fc_d[i];
            ep_q <= ep_d;
        end
    end

    // Status next-state: the clear is applied first so a same-cycle declaration wins.
    always_comb begin
        clr_vec  = clr_req ? clr_mask : '0;
        sticky_d = (sticky & ~clr_vec) | decl;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr_vec[i]) cnt_d[i] = '0;
            if (decl[i] && !(&cnt_d[i])) cnt_d[i] = cnt_d[i] + CNT_W'(1);
        end

        first_hit = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (first_ch == CH_W'(i) && clr_vec[i]) first_hit = 1'b1;
        end

        first_vld_d = first_vld;
        first_ch_d  = first_ch;
        if (first_vld && first_hit) begin
            first_vld_d = 1'b0;
            first_ch_d  = '0;
        end
        if (!first_vld_d && (|decl)) begin
            first_vld_d = 1'b1;
            first_ch_d  = lowest(decl);
        end
    end

    // Event pulse, clear acknowledge, sticky status, counters and first offender.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_vld   <= 1'b0;
            evt_mask  <= '0;
            evt_ch    <= '0;
            clr_ack   <= 1'b0;
            sticky    <= '0;
            irq       <= 1'b0;
            first_vld <= 1'b0;
            first_ch  <= '0;
            // NOTE: the counter array sits in flops, not RAM, so it can and must be reset
            // together with the rest of the status.
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
        end else begin
            evt_vld   <= |decl;
            evt_mask  <= decl;
            evt_ch    <= lowest(decl);
            clr_ack   <= clr_req;
            sticky    <= sticky_d;
            irq       <= |sticky_d;
            first_vld <= first_vld_d;
            first_ch  <= first_ch_d;
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Flatten the per-channel counters onto the output bus.
    always_comb begin
        evt_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) evt_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end

endmodule

// File: tb/tb_oe_contention_mon.sv
// Self-checking bench for oe_contention_mon: directed scenarios followed by a
// randomized phase, all compared every cycle against a run-length reference model.
module tb_oe_contention_mon;

    localparam int NUM_CH      = 2;
    localparam int FILT_CYCLES = 2;
    localparam int CNT_W       = 2;
    localparam int CH_W        = 5;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic                    clk;
    logic                    rst_n;
    logic                    enable;
    logic                    mode;
    logic [NUM_CH-1:0]       tst_drive;
    logic [NUM_CH-1:0]       tst_known;
    logic [NUM_CH-1:0]       dut_oe;
    logic [NUM_CH-1:0]       bus_x;
    logic                    clr_req;
    logic [NUM_CH-1:0]       clr_mask;
    logic                    clr_ack;
    logic                    evt_vld;
    logic [NUM_CH-1:0]       evt_mask;
    logic [CH_W-1:0]         evt_ch;
    logic [NUM_CH-1:0]       sticky;
    logic                    first_vld;
    logic [CH_W-1:0]         first_ch;
    logic [NUM_CH*CNT_W-1:0] evt_cnt;
    logic                    irq;

    int checks   = 0;
    int failures = 0;
    int n_evt;

    // Reference model state: length of the current unbroken qualifying run per pin.
    int                run   [NUM_CH];
    int                m_cnt [NUM_CH];
    logic [NUM_CH-1:0] m_sticky;
    logic [NUM_CH-1:0] m_evt_mask;
    logic              m_evt_vld;
    logic [CH_W-1:0]   m_evt_ch;
    logic              m_first_vld;
    logic [CH_W-1:0]   m_first_ch;
    logic              m_clr_ack;
    logic              m_irq;

    oe_contention_mon #(
        .NUM_CH(NUM_CH), .FILT_CYCLES(FILT_CYCLES), .CNT_W(CNT_W), .CH_W(CH_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
        .tst_drive(tst_drive), .tst_known(tst_known), .dut_oe(dut_oe), .bus_x(bus_x),
        .clr_req(clr_req), .clr_mask(clr_mask), .clr_ack(clr_ack),
        .evt_vld(evt_vld), .evt_mask(evt_mask), .evt_ch(evt_ch), .sticky(sticky),
        .first_vld(first_vld), .first_ch(first_ch), .evt_cnt(evt_cnt), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest_set(input logic [NUM_CH-1:0] v);
        for (int i = 0; i < NUM_CH; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            run[i]   = 0;
            m_cnt[i] = 0;
        end
        m_sticky    = '0;
        m_evt_mask  = '0;
        m_evt_vld   = 1'b0;
        m_evt_ch    = '0;
        m_first_vld = 1'b0;
        m_first_ch  = '0;
        m_clr_ack   = 1'b0;
        m_irq       = 1'b0;
    endtask

    // One clock of the specification's rules, using the inputs held during that cycle.
    task automatic model_step();
        logic [NUM_CH-1:0] d;
        bit                qi;
        d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            qi = enable && tst_drive[i] && tst_known[i] && (mode ? bus_x[i] : dut_oe[i]);
            run[i] = qi ? run[i] + 1 : 0;
            d[i] = (run[i] == FILT_CYCLES);
        end
        if (clr_req) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (clr_mask[i]) begin
                    m_sticky[i] = 1'b0;
                    m_cnt[i]    = 0;
                end
            end
            if (m_first_vld && clr_mask[int'(m_first_ch)]) begin
                m_first_vld = 1'b0;
                m_first_ch  = '0;
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (d[i]) begin
                m_sticky[i] = 1'b1;
                if (m_cnt[i] < CNT_MAX) m_cnt[i]++;
            end
        end
        if (!m_first_vld && d != '0) begin
            m_first_vld = 1'b1;
            m_first_ch  = CH_W'(lowest_set(d));
        end
        m_evt_mask = d;
        m_evt_vld  = (d != '0);
        m_evt_ch   = CH_W'(lowest_set(d));
        m_clr_ack  = clr_req;
        m_irq      = (m_sticky != '0);
    endtask

    task automatic check_all();
        logic [NUM_CH*CNT_W-1:0] e_cnt;
        for (int i = 0; i < NUM_CH; i++) e_cnt[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
        check("clr_ack",   32'(clr_ack),   32'(m_clr_ack));
        check("evt_vld",   32'(evt_vld),   32'(m_evt_vld));
        check("evt_mask",  32'(evt_mask),  32'(m_evt_mask));
        check("evt_ch",    32'(evt_ch),    32'(m_evt_ch));
        check("sticky",    32'(sticky),    32'(m_sticky));
        check("first_vld", 32'(first_vld), 32'(m_first_vld));
        check("first_ch",  32'(first_ch),  32'(m_first_ch));
        check("evt_cnt",   32'(evt_cnt),   32'(e_cnt));
        check("irq",       32'(irq),       32'(m_irq));
    endtask

    // Advance one clock, update the model, sample outputs after the edge, return at the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        check_all();
        if (evt_vld) n_evt++;
        @(negedge clk);
    endtask

    task automatic drive_idle();
        enable    = 1'b1;
        mode      = 1'b0;
        tst_drive = '0;
        tst_known = '0;
        dut_oe    = '0;
        bus_x     = '0;
        clr_req   = 1'b0;
        clr_mask  = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // OE mode, channel 1 in continuous contention for 10 cycles.
        n_evt = 0;
        tst_drive = 2'b10; tst_known = 2'b10; dut_oe = 2'b10;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (k == 1) begin
                check("oe_evt_mask", 32'(evt_mask), 32'h2);
                check("oe_evt_ch",   32'(evt_ch),   32'h1);
            end
        end
        check("oe_single_event", 32'(n_evt),   32'd1);
        check("oe_sticky",       32'(sticky),  32'h2);
        check("oe_first_ch",     32'(first_ch), 32'h1);
        check("oe_irq",          32'(irq),      32'h1);
        drive_idle();
        cycle();

        // Glitch filter: 1 on, 1 off, 1 on, 1 off gives nothing; 3 on gives one event.
        n_evt = 0;
        for (int k = 0; k < 4; k++) begin
            tst_drive = 2'b01; tst_known = 2'b01; dut_oe = (k % 2 == 0) ? 2'b01 : 2'b00;
            cycle();
        end
        check("glitch_no_event", 32'(n_evt), 32'd0);
        dut_oe = 2'b01;
        repeat (3) cycle();
        check("glitch_then_one_event", 32'(n_evt), 32'd1);
        drive_idle();
        cycle();

        // Resolved-X mode: unknown tester data blocks qualification, dut_oe is ignored.
        n_evt = 0;
        mode = 1'b1; tst_drive = 2'b01; tst_known = 2'b00; bus_x = 2'b01; dut_oe = 2'b00;
        repeat (3) cycle();
        check("xmode_unknown_no_event", 32'(n_evt), 32'd0);
        tst_known = 2'b01;
        cycle();
        cycle();
        check("xmode_evt_mask", 32'(evt_mask), 32'h1);
        drive_idle();
        cycle();

        // Clear everything, then both channels qualify together.
        clr_req = 1'b1; clr_mask = 2'b11;
        cycle();
        clr_req = 1'b0; clr_mask = 2'b00;
        check("clear_first_vld", 32'(first_vld), 32'h0);
        tst_drive = 2'b11; tst_known = 2'b11; dut_oe = 2'b11;
        cycle();
        cycle();
        check("simul_evt_mask", 32'(evt_mask), 32'h3);
        check("simul_evt_ch",   32'(evt_ch),   32'h0);
        check("simul_first_ch", 32'(first_ch), 32'h0);
        drive_idle();
        cycle();

        // Five more episodes on channel 0 saturate its 2-bit counter.
        repeat (5) begin
            tst_drive = 2'b01; tst_known = 2'b01; dut_oe = 2'b01;
            cycle();
            cycle();
            drive_idle();
            cycle();
        end
        check("sat_cnt0", 32'(evt_cnt[CNT_W-1:0]), 32'd3);

        // Clear of channel 0 in the same cycle it is declared: the declaration wins.
        tst_drive = 2'b01; tst_known = 2'b01; dut_oe = 2'b01;
        cycle();
        clr_req = 1'b1; clr_mask = 2'b01;
        cycle();
        check("race_clr_ack", 32'(clr_ack),             32'h1);
        check("race_sticky0", 32'(sticky[0]),           32'h1);
        check("race_cnt0",    32'(evt_cnt[CNT_W-1:0]),  32'd1);
        drive_idle();
        cycle();
        clr_req = 1'b1; clr_mask = 2'b11;
        cycle();
        clr_req = 1'b0; clr_mask = 2'b00;
        cycle();
        check("clrall_sticky",    32'(sticky),    32'h0);
        check("clrall_irq",       32'(irq),       32'h0);
        check("clrall_first_vld", 32'(first_vld), 32'h0);
        check("clrall_cnt",       32'(evt_cnt),   32'h0);

        // Asynchronous reset in the middle of an episode.
        tst_drive = 2'b11; tst_known = 2'b11; dut_oe = 2'b11;
        repeat (3) cycle();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check("areset_irq", 32'(irq), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        n_evt = 0;
        cycle();
        check("areset_no_early_event", 32'(n_evt), 32'd0);
        cycle();
        check("areset_fresh_event", 32'(evt_mask), 32'h3);
        drive_idle();
        cycle();

        // Randomized phase against the model.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            enable    = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < NUM_CH; i++) begin
                tst_drive[i] = ($urandom_range(0, 4) != 0);
                tst_known[i] = ($urandom_range(0, 4) != 0);
                dut_oe[i]    = ($urandom_range(0, 3) != 0);
                bus_x[i]     = ($urandom_range(0, 3) != 0);
            end
            clr_req  = ($urandom_range(0, 7) == 0);
            clr_mask = NUM_CH'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
